// File: rtl/layer_compositor.sv
// Three-stage sprite layer compositor: priority select, palette lookup, fade scaling.
// A small FSM steps the global fade level once per frame tick.
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 6,
    parameter int PAL_DEPTH  = 64,
    parameter int TRANSP_IDX = 0
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    pix_valid_in,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [NUM_LAYERS-1:0]   layer_hit,
    input  logic [NUM_LAYERS*8-1:0] layer_idx,
    input  logic [7:0]              bg_idx,
    input  logic                    pal_we,
    input  logic [IDX_W-1:0]        pal_waddr,
    input  logic [23:0]             pal_wdata,
    input  logic                    fade_start,
    input  logic                    fade_dir,
    input  logic                    frame_tick,
    output logic                    fade_busy,
    output logic                    pix_valid_out,
    output logic [9:0]              DrawX_out,
    output logic [9:0]              DrawY_out,
    output logic [7:0]              VGA_R,
    output logic [7:0]              VGA_G,
    output logic [7:0]              VGA_B
);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_e;

    localparam logic [IDX_W-1:0] TRANSP    = IDX_W'(TRANSP_IDX);
    localparam logic [4:0]       LEVEL_MAX = 5'd16;

    fade_state_e      state_d, state_q;
    logic [4:0]       level_d, level_q;
    logic             fade_busy_q;

    logic [IDX_W-1:0] sel_d, sel_q;
    logic             s1_valid_q, s2_valid_q, s3_valid_q;
    logic [9:0]       s1_x_q, s1_y_q, s2_x_q, s2_y_q, s3_x_q, s3_y_q;
    logic [23:0]      color_d, color_q;
    logic [7:0]       r_d, g_d, b_d, r_q, g_q, b_q;
    logic [12:0]      prod_r, prod_g, prod_b;

    logic [23:0]      pal_q [PAL_DEPTH];
    logic             rd_in_range, wr_in_range;
    logic             found;
    logic             unused_bits;

    assign unused_bits = ^{bg_idx, layer_idx};

    // Range checks only exist when the palette does not fill the index space.
    if (PAL_DEPTH < (1 << IDX_W)) begin : g_partial_pal
        assign rd_in_range = (sel_q < IDX_W'(PAL_DEPTH));
        assign wr_in_range = (pal_waddr < IDX_W'(PAL_DEPTH));
    end else begin : g_full_pal
        assign rd_in_range = 1'b1;
        assign wr_in_range = 1'b1;
    end

    always_comb begin
        sel_d = bg_idx[IDX_W-1:0];
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && layer_hit[i] && (layer_idx[i*8 +: IDX_W] != TRANSP)) begin
                sel_d = layer_idx[i*8 +: IDX_W];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        color_d = rd_in_range ? pal_q[sel_q] : '0;
    end

    always_comb begin
        prod_r = 13'(color_q[23:16]) * 13'(level_q);
        prod_g = 13'(color_q[15:8])  * 13'(level_q);
        prod_b = 13'(color_q[7:0])   * 13'(level_q);
        r_d    = 8'(prod_r >> 4);
        g_d    = 8'(prod_g >> 4);
        b_d    = 8'(prod_b >> 4);
    end

    // A tick at the end stop (0 out / 16 in) exits without moving the level.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            IDLE: begin
                if (fade_start) state_d = fade_dir ? FADE_IN : FADE_OUT;
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (level_q != 5'd0) level_d = level_q - 5'd1;
                    if (level_q <= 5'd1) state_d = IDLE;
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (level_q != LEVEL_MAX) level_d = level_q + 5'd1;
                    if (level_q >= LEVEL_MAX - 5'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            level_q     <= LEVEL_MAX;
            fade_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            fade_busy_q <= (state_d != IDLE);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < PAL_DEPTH; i++) pal_q[i] <= '0;
        end else if (pal_we && wr_in_range) begin
            pal_q[pal_waddr] <= pal_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            color_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            s3_valid_q <= 1'b0;
            s3_x_q     <= '0;
            s3_y_q     <= '0;
        end else begin
            sel_q      <= sel_d;
            s1_valid_q <= pix_valid_in;
            s1_x_q     <= DrawX;
            s1_y_q     <= DrawY;
            color_q    <= color_d;
            s2_valid_q <= s1_valid_q;
            s2_x_q     <= s1_x_q;
            s2_y_q     <= s1_y_q;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            s3_valid_q <= s2_valid_q;
            s3_x_q     <= s2_x_q;
            s3_y_q     <= s2_y_q;
        end
    end

    assign fade_busy     = fade_busy_q;
    assign pix_valid_out = s3_valid_q;
    assign DrawX_out     = s3_x_q;
    assign DrawY_out     = s3_y_q;
    assign VGA_R         = r_q;
    assign VGA_G         = g_q;
    assign VGA_B         = b_q;

endmodule
